// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with per-tick debounce of press and release.
// Emits a one-cycle key_valid pulse and a key_down level per accepted key.
module keypad_scan #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_tick,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEB,
    S_PRESSED,
    S_RELEASE
  } state_t;

  localparam logic [7:0] DB = 8'(DEBOUNCE);

  state_t     state;
  logic [3:0] sync1;
  logic [3:0] rows_s;
  logic [3:0] pat;
  logic [1:0] col_idx;
  logic [1:0] row_idx;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       fire;
  logic       one_hot;
  logic [1:0] hot_idx;
  logic [1:0] col_adv;

  function automatic logic [3:0] col_dec(input logic [1:0] c);
    logic [3:0] d;
    d = 4'b1110;
    case (c)
      2'd0: d = 4'b1110;
      2'd1: d = 4'b1101;
      2'd2: d = 4'b1011;
      2'd3: d = 4'b0111;
      default: d = 4'b1110;
    endcase
    return d;
  endfunction

  always_comb begin
    one_hot = 1'b1;
    hot_idx = 2'd0;
    unique case (1'b1)
      rows_s == 4'b1110: hot_idx = 2'd0;
      rows_s == 4'b1101: hot_idx = 2'd1;
      rows_s == 4'b1011: hot_idx = 2'd2;
      rows_s == 4'b0111: hot_idx = 2'd3;
      default:           one_hot = 1'b0;
    endcase
  end

  assign cnt_nxt = (cnt >= DB) ? cnt : cnt + 8'd1;
  assign col_adv = col_idx + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_SCAN;
      sync1     <= 4'hF;
      rows_s    <= 4'hF;
      pat       <= 4'hF;
      col_idx   <= 2'd0;
      col_n     <= 4'b1110;
      row_idx   <= 2'd0;
      cnt       <= 8'd0;
      fire      <= 1'b0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      sync1     <= row_n;
      rows_s    <= sync1;
      key_valid <= fire;
      fire      <= 1'b0;
      // Outputs follow the accepting tick by one clock.
      if (fire) begin
        key_code <= {row_idx, col_idx};
        key_down <= 1'b1;
      end
      if (scan_tick) begin
        case (state)
          S_SCAN: begin
            if (one_hot) begin
              pat     <= rows_s;
              row_idx <= hot_idx;
              cnt     <= 8'd1;
              state   <= S_DEB;
            end else begin
              col_idx <= col_adv;
              col_n   <= col_dec(col_adv);
            end
          end
          S_DEB: begin
            if (rows_s == pat) begin
              cnt <= cnt_nxt;
              if (cnt_nxt == DB) begin
                state <= S_PRESSED;
                fire  <= 1'b1;
              end
            end else begin
              state   <= S_SCAN;
              col_idx <= col_adv;
              col_n   <= col_dec(col_adv);
            end
          end
          S_PRESSED: begin
            if (rows_s == 4'hF) begin
              cnt   <= 8'd1;
              state <= S_RELEASE;
            end
          end
          S_RELEASE: begin
            if (rows_s == 4'hF) begin
              cnt <= cnt_nxt;
              if (cnt_nxt == DB) begin
                key_down <= 1'b0;
                col_idx  <= col_adv;
                col_n    <= col_dec(col_adv);
                state    <= S_SCAN;
              end
            end else begin
              state <= S_PRESSED;
            end
          end
          default: state <= S_SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with DEBOUNCE=4.
// Drives rows directly, strobes scan_tick, checks outputs on falling edges.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_tick = 1'b0;
  logic [3:0] row_n = 4'hF;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  int passed = 0;
  int total = 0;
  int vcount = 0;

  keypad_scan #(.DEBOUNCE(4)) dut (
    .clk(clk),
    .reset(reset),
    .scan_tick(scan_tick),
    .row_n(row_n),
    .col_n(col_n),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_down(key_down)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (key_valid === 1'b1) vcount++;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    scan_tick = 1'b1;
    @(negedge clk);
    scan_tick = 1'b0;
  endtask

  task automatic rows(input logic [3:0] r);
    row_n = r;
    clks(3);
  endtask

  initial begin
    logic [3:0] seq [4];
    seq[0] = 4'b1101;
    seq[1] = 4'b1011;
    seq[2] = 4'b0111;
    seq[3] = 4'b1110;

    clks(3);
    reset = 1'b0;
    clks(1);
    chk("rst_col", 8'(col_n), 8'h0E);
    chk("rst_code", 8'(key_code), 8'h0);
    chk("rst_valid", 8'(key_valid), 8'h0);
    chk("rst_down", 8'(key_down), 8'h0);

    for (int i = 0; i < 8; i++) begin
      tick();
      chk("idle_col", 8'(col_n), 8'(seq[i % 4]));
    end
    chk("idle_nvalid", 8'(vcount), 8'd0);

    tick();
    chk("to_col1", 8'(col_n), 8'h0D);
    rows(4'b1011);
    tick();
    chk("deb_hold", 8'(col_n), 8'h0D);
    tick();
    tick();
    tick();
    chk("lat_early", 8'(key_valid), 8'h0);
    clks(1);
    chk("pulse", 8'(key_valid), 8'h1);
    chk("code", 8'(key_code), 8'h09);
    chk("down", 8'(key_down), 8'h1);
    clks(1);
    chk("pulse_end", 8'(key_valid), 8'h0);

    rows(4'hF);
    tick();
    tick();
    rows(4'b1011);
    tick();
    chk("glitch_down", 8'(key_down), 8'h1);
    chk("glitch_col", 8'(col_n), 8'h0D);
    chk("glitch_nv", 8'(vcount), 8'd1);

    rows(4'hF);
    tick();
    tick();
    tick();
    chk("rel3_down", 8'(key_down), 8'h1);
    tick();
    chk("rel4_down", 8'(key_down), 8'h0);
    chk("rel_col", 8'(col_n), 8'h0B);

    tick();
    tick();
    tick();
    chk("back_col1", 8'(col_n), 8'h0D);
    rows(4'b1011);
    tick();
    tick();
    rows(4'hF);
    tick();
    chk("bounce_col", 8'(col_n), 8'h0B);
    chk("bounce_nv", 8'(vcount), 8'd1);
    chk("code_hold", 8'(key_code), 8'h09);

    rows(4'b1001);
    tick();
    chk("multi_col3", 8'(col_n), 8'h07);
    tick();
    chk("multi_col0", 8'(col_n), 8'h0E);
    chk("multi_nv", 8'(vcount), 8'd1);

    rows(4'hF);
    tick();
    chk("pre_deb", 8'(col_n), 8'h0D);
    rows(4'b0111);
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    row_n = 4'hF;
    @(negedge clk);
    reset = 1'b0;
    chk("rdeb_col", 8'(col_n), 8'h0E);
    chk("rdeb_code", 8'(key_code), 8'h0);
    chk("rdeb_down", 8'(key_down), 8'h0);
    clks(3);
    tick();
    tick();
    chk("rdeb_nv", 8'(vcount), 8'd1);
    chk("rdeb_scan", 8'(col_n), 8'h0B);

    tick();
    tick();
    chk("to_col0", 8'(col_n), 8'h0E);
    rows(4'b0111);
    tick();
    tick();
    tick();
    tick();
    clks(1);
    chk("p2_valid", 8'(key_valid), 8'h1);
    chk("p2_code", 8'(key_code), 8'h0C);
    clks(1);
    reset = 1'b1;
    scan_tick = 1'b1;
    row_n = 4'hF;
    @(negedge clk);
    reset = 1'b0;
    scan_tick = 1'b0;
    chk("rpr_col", 8'(col_n), 8'h0E);
    chk("rpr_code", 8'(key_code), 8'h0);
    chk("rpr_down", 8'(key_down), 8'h0);
    chk("rpr_valid", 8'(key_valid), 8'h0);
    clks(3);
    tick();
    chk("rpr_scan", 8'(col_n), 8'h0D);
    chk("final_nv", 8'(vcount), 8'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
